// File: rtl/wb_fib_poller.sv
// wb_fib_poller: Wishbone initiator serving host register commands and periodic Fibonacci-value polls
module wb_fib_poller #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int TIMEOUT = 16,
  parameter int POLL_INTERVAL = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [5:0]  cmd_off_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  input  logic        poll_en_i,
  output logic [29:0] poll_val_o,
  output logic        poll_upd_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(POLL_INTERVAL + 1);
  localparam logic [5:0] POLL_OFF = 6'h14;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state, state_n;
  logic run, we, is_poll, pending;
  logic [5:0] off;
  logic [31:0] dat;
  logic [TW-1:0] tcnt;
  logic [IW-1:0] icnt;
  logic accept, misalign, poll_start, expired, done, wrap, in_bus;
  // run keeps the command port closed until the first clock edge after reset release
  assign cmd_ready_o = run && state == IDLE;
  assign accept = cmd_valid_i && cmd_ready_o;
  assign misalign = |cmd_off_i[1:0];
  assign poll_start = cmd_ready_o && !cmd_valid_i && pending;
  assign expired = tcnt == TW'(TIMEOUT - 1);
  assign in_bus = state == BUS;
  assign done = in_bus && (wbm_ack_i || expired);
  assign wrap = poll_en_i && icnt == IW'(POLL_INTERVAL - 1);
  assign wbm_cyc_o = in_bus;
  assign wbm_stb_o = in_bus;
  assign wbm_we_o = in_bus && we;
  assign wbm_sel_o = in_bus ? 4'hF : 4'h0;
  assign wbm_adr_o = in_bus ? BASE_ADDRESS + {26'd0, off} : 32'h0;
  assign wbm_dat_o = in_bus ? dat : 32'h0;
  assign rsp_valid_o = state == RESP;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? (misalign ? RESP : BUS) : (poll_start ? BUS : IDLE);
      BUS: state_n = done ? (is_poll ? IDLE : RESP) : BUS;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      run <= 1'b0;
      off <= '0;
      we <= 1'b0;
      dat <= '0;
      is_poll <= 1'b0;
      tcnt <= '0;
      icnt <= '0;
      pending <= 1'b0;
      poll_upd_o <= 1'b0;
      poll_val_o <= '0;
      rsp_err_o <= 1'b0;
      rsp_dat_o <= '0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        off <= cmd_off_i;
        we <= cmd_we_i;
        dat <= cmd_dat_i;
        is_poll <= 1'b0;
      end else if (poll_start) begin
        off <= POLL_OFF;
        we <= 1'b0;
        dat <= '0;
        is_poll <= 1'b1;
      end
      tcnt <= in_bus ? tcnt + TW'(1) : '0;
      icnt <= (!poll_en_i || wrap) ? '0 : icnt + IW'(1);
      pending <= poll_en_i && ((pending && !(done && is_poll)) || wrap);
      poll_upd_o <= done && is_poll && wbm_ack_i;
      if (done && is_poll && wbm_ack_i) poll_val_o <= wbm_dat_i[29:0];
      if (accept && misalign) begin
        rsp_err_o <= 1'b1;
        rsp_dat_o <= '0;
      end else if (done && !is_poll) begin
        rsp_err_o <= !wbm_ack_i;
        rsp_dat_o <= (wbm_ack_i && !we) ? wbm_dat_i : '0;
      end
    end
endmodule
